// File: rtl/trng_out_fifo_if.sv
// Stream and status bundle between the AES conditioner,
// the output FIFO and the downstream consumer.
interface trng_out_fifo_if #(
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic          vld_in;
   logic [31:0]   data_in;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic [AW:0]   level;
   logic          full;
   logic          overflow;
   logic          rep_err;
   logic          clr_err;
   logic [15:0]   blk_cnt;

   modport master (
      output vld_in,
      output data_in,
      output out_ready,
      output clr_err,
      input  out_valid,
      input  out_data,
      input  level,
      input  full,
      input  overflow,
      input  rep_err,
      input  blk_cnt
   );

   modport slave (
      input  vld_in,
      input  data_in,
      input  out_ready,
      input  clr_err,
      output out_valid,
      output out_data,
      output level,
      output full,
      output overflow,
      output rep_err,
      output blk_cnt
   );
endinterface

// File: rtl/trng_out_fifo.sv
// FWFT output buffer for conditioned TRNG words with block
// counting and sticky overflow / repeated-word health flags.
module trng_out_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   trng_out_fifo_if.slave   bus
);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [31:0]   mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          valid_q, valid_d;
   logic          full_q, full_d;
   logic          ovf_q, ovf_d;
   logic          rep_q, rep_d;
   logic [31:0]   prev_q, prev_d;
   logic          pvld_q, pvld_d;
   logic [1:0]    wcnt_q, wcnt_d;
   logic [15:0]   blk_q, blk_d;

   logic          pop;
   logic          push;
   logic          drop;
   logic          rep_hit;

   // A pop in the same cycle frees the slot, so a full FIFO
   // can still take a word.
   always_comb begin
      pop     = valid_q & bus.out_ready;
      push    = bus.vld_in & (~full_q | pop);
      drop    = bus.vld_in & full_q & ~pop;
      rep_hit = push & pvld_q & (bus.data_in == prev_q);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
      valid_d = (level_d != '0);
      full_d  = (level_d == LVL_FULL);
   end

   // Error set takes priority over a simultaneous clear.
   always_comb begin
      ovf_d  = ovf_q;
      rep_d  = rep_q;
      pvld_d = pvld_q;
      prev_d = prev_q;
      if (bus.clr_err) begin
         ovf_d  = 1'b0;
         rep_d  = 1'b0;
         pvld_d = 1'b0;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end
      if (rep_hit) begin
         rep_d = 1'b1;
      end
      if (push) begin
         prev_d = bus.data_in;
         pvld_d = 1'b1;
      end
   end

   always_comb begin
      wcnt_d = wcnt_q;
      blk_d  = blk_q;
      if (push) begin
         wcnt_d = wcnt_q + 2'd1;
         if (wcnt_q == 2'd3) begin
            blk_d = blk_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         rep_q    <= 1'b0;
         prev_q   <= '0;
         pvld_q   <= 1'b0;
         wcnt_q   <= '0;
         blk_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         valid_q  <= valid_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
         rep_q    <= rep_d;
         prev_q   <= prev_d;
         pvld_q   <= pvld_d;
         wcnt_q   <= wcnt_d;
         blk_q    <= blk_d;
      end
   end

   // Storage needs no reset; out_valid gates its contents.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.data_in;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_data  = mem_q[rd_ptr_q];
   assign bus.level     = level_q;
   assign bus.full      = full_q;
   assign bus.overflow  = ovf_q;
   assign bus.rep_err   = rep_q;
   assign bus.blk_cnt   = blk_q;
endmodule

// File: tb/tb_trng_out_fifo.sv
// Directed bench for trng_out_fifo: ordering, wrap,
// overflow, health flag, block count and reset.
module tb_trng_out_fifo;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   trng_out_fifo_if #(.DEPTH(DEPTH)) bus ();

   trng_out_fifo #(.DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      bus.vld_in  = 1'b1;
      bus.data_in = w;
      tick();
      bus.vld_in  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse_clr();
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.vld_in    = 1'b0;
      bus.data_in   = '0;
      bus.out_ready = 1'b0;
      bus.clr_err   = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      chk("rst_level", 32'(bus.level), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      chk("rst_rep", 32'(bus.rep_err), 32'd0);
      chk("rst_blk", 32'(bus.blk_cnt), 32'd0);

      // test 1: one block, consumer stalled
      push(32'hA000_000A);
      chk("t1_lat_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_lat_level", 32'(bus.level), 32'd1);
      push(32'hB000_000B);
      push(32'hC000_000C);
      push(32'hD000_000D);
      chk("t1_level", 32'(bus.level), 32'd4);
      chk("t1_blk", 32'(bus.blk_cnt), 32'd1);
      chk("t1_head", bus.out_data, 32'hA000_000A);
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_ovf", 32'(bus.overflow), 32'd0);
      chk("t1_rep", 32'(bus.rep_err), 32'd0);

      // test 2: drain in order
      bus.out_ready = 1'b1;
      chk("t2_w0", bus.out_data, 32'hA000_000A);
      tick();
      chk("t2_w1", bus.out_data, 32'hB000_000B);
      chk("t2_lvl3", 32'(bus.level), 32'd3);
      tick();
      chk("t2_w2", bus.out_data, 32'hC000_000C);
      tick();
      chk("t2_w3", bus.out_data, 32'hD000_000D);
      tick();
      chk("t2_level", 32'(bus.level), 32'd0);
      chk("t2_valid", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;

      // test 3: fill past capacity
      do_reset();
      for (int i = 0; i < 17; i++) begin
         push(32'h3000_0000 + 32'(i));
      end
      chk("t3_level", 32'(bus.level), 32'd16);
      chk("t3_full", 32'(bus.full), 32'd1);
      chk("t3_ovf", 32'(bus.overflow), 32'd1);
      chk("t3_blk", 32'(bus.blk_cnt), 32'd4);
      chk("t3_head", bus.out_data, 32'h3000_0000);

      pulse_clr();
      chk("clr_ovf", 32'(bus.overflow), 32'd0);
      chk("clr_level", 32'(bus.level), 32'd16);

      // test 4: push+pop while full, then wrap
      bus.out_ready = 1'b1;
      for (int k = 0; k < 21; k++) begin
         chk("t4_rd",
             bus.out_data,
             (k < 16) ? 32'h3000_0000 + 32'(k)
                      : 32'h4000_0000 + 32'(k - 16));
         bus.vld_in  = 1'b1;
         bus.data_in = 32'h4000_0000 + 32'(k);
         tick();
         if (k == 0) begin
            chk("t4_lvl", 32'(bus.level), 32'd16);
            chk("t4_ovf", 32'(bus.overflow), 32'd0);
            chk("t4_full", 32'(bus.full), 32'd1);
         end
      end
      bus.vld_in = 1'b0;
      chk("t4_lvl_end", 32'(bus.level), 32'd16);
      chk("t4_blk", 32'(bus.blk_cnt), 32'd9);
      chk("t4_ovf_end", 32'(bus.overflow), 32'd0);
      for (int k = 5; k < 21; k++) begin
         chk("t4_drain", bus.out_data,
             32'h4000_0000 + 32'(k));
         tick();
      end
      chk("t4_empty", 32'(bus.out_valid), 32'd0);
      chk("t4_lvl0", 32'(bus.level), 32'd0);

      // test 5: repeated-word health flag
      push(32'h1234_5678);
      chk("t5_emptypush", 32'(bus.level), 32'd1);
      chk("t5_rep0", 32'(bus.rep_err), 32'd0);
      push(32'h1234_5678);
      chk("t5_rep1", 32'(bus.rep_err), 32'd1);
      chk("t5_lvl", 32'(bus.level), 32'd1);
      pulse_clr();
      chk("t5_clr", 32'(bus.rep_err), 32'd0);
      push(32'h1234_5678);
      chk("t5_nocmp", 32'(bus.rep_err), 32'd0);
      bus.clr_err = 1'b1;
      push(32'h1234_5678);
      bus.clr_err = 1'b0;
      chk("t5_setwins", 32'(bus.rep_err), 32'd1);
      pulse_clr();
      chk("t5_clr2", 32'(bus.rep_err), 32'd0);
      tick();
      chk("t5_drained", 32'(bus.level), 32'd0);

      // test 6: reset mid-block
      bus.out_ready = 1'b0;
      push(32'h5000_0001);
      push(32'h5000_0001);
      chk("t6_pre_lvl", 32'(bus.level), 32'd2);
      chk("t6_pre_rep", 32'(bus.rep_err), 32'd1);
      do_reset();
      chk("t6_level", 32'(bus.level), 32'd0);
      chk("t6_valid", 32'(bus.out_valid), 32'd0);
      chk("t6_blk", 32'(bus.blk_cnt), 32'd0);
      chk("t6_rep", 32'(bus.rep_err), 32'd0);
      chk("t6_ovf", 32'(bus.overflow), 32'd0);
      push(32'h6000_0000);
      push(32'h6000_0001);
      chk("t6_blk_half", 32'(bus.blk_cnt), 32'd0);
      push(32'h6000_0002);
      push(32'h6000_0003);
      chk("t6_blk1", 32'(bus.blk_cnt), 32'd1);
      chk("t6_lvl4", 32'(bus.level), 32'd4);
      chk("t6_head", bus.out_data, 32'h6000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
